karaoke_echo: RTL and testbench

KARAOKE_ECHO -- requirements
Module: karaoke_echo

---
 rtl/karaoke_echo.sv | 157 +++++++++++++++
 tb/tb_karaoke_echo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/karaoke_echo.sv
// karaoke_echo: single-tap feedback echo for the decimated audio stream.
//
// Each accepted sample x is mixed with the word written DEPTH-ring entries
// earlier (delay_len samples back), scaled by fb_gain/16, saturated, sent
// out and written back into the ring. The result is a decaying echo.
//
// Ports
//   clk        : single clock, shared with the decimation chain
//   reset      : synchronous, active-high
//   in_sample  : signed input sample
//   in_valid   : one-cycle strobe for in_sample
//   enable     : 1 = echo mixed in, 0 = bypass (input passes bit-exact)
//   delay_len  : echo delay in samples, 0 = no echo
//   fb_gain    : unsigned Q0.4 feedback gain
//   out_sample : processed signed sample
//   out_valid  : one-cycle strobe, 3 cycles after the accepted in_valid
//   overrun    : sticky, set when an in_valid lands while busy
module karaoke_echo #(
  parameter  int DEPTH  = 1024,
  parameter  int DATA_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  input  logic              enable,
  input  logic [AW-1:0]     delay_len,
  input  logic [3:0]        fb_gain,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_valid,
  output logic              overrun
);

  localparam int XW = DATA_W + 5;  // full-precision mix width
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

  state_t state, state_nxt;
  logic   accept, mix_go, drop;

  // Latched per-sample parameters: live inputs are never consulted after
  // the accepting edge, so mid-sample changes cannot leak in.
  logic [DATA_W-1:0] x_q;
  logic              en_q;
  logic [AW-1:0]     dly_q;
  logic [3:0]        gain_q;

  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       fill_cnt;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en, wr_en;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              tap_ok;
  logic [DATA_W-1:0] d;
  logic signed [XW-1:0] d_ext, gain_ext, x_ext, prod, scaled, y_full;
  logic              y_fits;
  logic [DATA_W-1:0] y_sat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mix_go    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        drop      = in_valid;
        state_nxt = MIX;
      end
      MIX: begin
        drop      = in_valid;
        mix_go    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------ mixer
  // The tap is gated off until the ring actually holds delay_len written
  // samples, so whatever the RAM held at power-up never reaches the output.
  assign tap_ok = en_q && (dly_q != '0) && (fill_cnt >= {1'b0, dly_q});
  assign d      = tap_ok ? rd_data : '0;

  always_comb begin
    d_ext    = {{5{d[DATA_W-1]}}, d};
    gain_ext = {{(DATA_W+1){1'b0}}, gain_q};
    x_ext    = {{5{x_q[DATA_W-1]}}, x_q};
    prod     = d_ext * gain_ext;
    scaled   = prod >>> 4;          // floors toward -inf
    y_full   = x_ext + scaled;
    // In range when all bits above the sample sign bit match it.
    y_fits   = (y_full[XW-1:DATA_W-1] == {6{y_full[XW-1]}});
    if (y_fits)          y_sat = y_full[DATA_W-1:0];
    else if (y_full[XW-1]) y_sat = Y_MIN;
    else                 y_sat = Y_MAX;
  end

  // --------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      en_q       <= 1'b0;
      dly_q      <= '0;
      gain_q     <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        x_q    <= in_sample;
        en_q   <= enable;
        dly_q  <= delay_len;
        gain_q <= fb_gain;
      end
      if (drop) overrun <= 1'b1;
      if (mix_go) begin
        out_sample <= y_sat;
        out_valid  <= 1'b1;
        wr_ptr     <= wr_ptr + AW'(1);  // power-of-two ring wraps naturally
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + (AW+1)'(1);
      end
    end
  end

  // ------------------------------------------------------ delay line
  // Plain read/write ports with no reset so it maps onto block RAM. Reset
  // only suppresses the write, which abandons a sample caught in MIX.
  assign rd_addr = wr_ptr - delay_len;
  assign rd_en   = accept & ~reset;
  assign wr_en   = mix_go & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= y_sat;
    if (rd_en) rd_data     <= mem[rd_addr];
  end

endmodule

// File: tb/tb_karaoke_echo.sv
module tb_karaoke_echo;
  localparam int DW = 16;
  localparam int DEPTH = 1024;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_sample;
  logic                 in_valid;
  logic                 enable;
  logic [AW-1:0]        delay_len;
  logic [3:0]           fb_gain;
  logic signed [DW-1:0] out_sample;
  logic                 out_valid;
  logic                 overrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  karaoke_echo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .enable(enable), .delay_len(delay_len), .fb_gain(fb_gain),
    .out_sample(out_sample), .out_valid(out_valid), .overrun(overrun)
  );

  typedef struct {
    bit                   rst;   // reset before applying this vector
    logic signed [DW-1:0] x;
    bit                   en;
    logic [AW-1:0]        dly;
    logic [3:0]           g;
    logic signed [DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input int x, input bit en, input int dly,
                     input int g, input int exp);
    vec_t v;
    v.rst = rst; v.x = DW'(x); v.en = en; v.dly = AW'(dly); v.g = 4'(g);
    v.exp = DW'(exp);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Called and returning at #1 after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Strobe one sample, then scramble the live controls while it is in
  // flight. Reports the first output seen, its cycle offset from the
  // strobe cycle, and how many out_valid pulses appeared in 5 cycles.
  task automatic send(input logic signed [DW-1:0] x, input bit en,
                      input logic [AW-1:0] dl, input logic [3:0] g,
                      output logic signed [DW-1:0] y, output int lat,
                      output int pulses);
    in_sample = x; enable = en; delay_len = dl; fb_gain = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; enable = ~en; delay_len = '0; fb_gain = '0;
    in_sample = -1;
    lat = 0; pulses = 0; y = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin lat = k; y = out_sample; end
      end
    end
  endtask

  initial begin
    logic signed [DW-1:0] y;
    int lat, pulses, p;

    reset = 1'b1; in_valid = 1'b0; in_sample = '0; enable = 1'b0;
    delay_len = '0; fb_gain = '0;
    @(posedge clk); #1;
    do_reset();

    // Quiet after reset.
    for (int i = 0; i < 10; i++) begin
      chk("idle_outs", {out_valid, overrun, 16'(out_sample)}, 0);
      @(posedge clk); #1;
    end

    // Decaying echo: delay 4, gain 1/2.
    add(1, 16000, 1, 4, 8, 16000);
    for (int i = 1; i <= 12; i++)
      add(0, 0, 1, 4, 8, (i == 4) ? 8000 : (i == 8) ? 4000 : (i == 12) ? 2000 : 0);
    // History present, but delay 0 / bypass must pass the input through.
    add(0, 1234, 1, 0, 15, 1234);
    add(0, -5, 0, 4, 15, -5);
    // Saturation, both rails.
    add(1, 30000, 1, 1, 15, 30000);
    add(0, 30000, 1, 1, 15, 32767);
    add(0, 30000, 1, 1, 15, 32767);
    add(1, -30000, 1, 1, 15, -30000);
    add(0, -30000, 1, 1, 15, -32768);
    add(0, -30000, 1, 1, 15, -32768);
    // Bypass keeps writing history; echo resumes from bypassed samples.
    add(1, 1000, 1, 2, 8, 1000);
    add(0, 2000, 1, 2, 8, 2000);
    add(0, 500, 0, 2, 8, 500);
    add(0, -3, 0, 2, 8, -3);
    add(0, 0, 1, 2, 8, 250);
    add(0, 0, 1, 2, 8, -2);      // 8*-3 = -24, >>>4 floors to -2
    add(0, -32768, 0, 2, 15, -32768);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].x, tbl[i].en, tbl[i].dly, tbl[i].g, y, lat, pulses);
      chk($sformatf("vec%0d_value", i), int'(y), int'(tbl[i].exp));
      chk($sformatf("vec%0d_lat_pulses", i), lat * 10 + pulses, 31);
    end

    // Back-to-back strobes: second one dropped, overrun sticky.
    do_reset();
    in_sample = 111; enable = 1'b0; delay_len = '0; fb_gain = '0;
    in_valid = 1'b1;                                   // cycle t
    @(posedge clk); #1;                                // t+1 (READ)
    in_sample = 222;
    chk("ovr_t1_flag", overrun, 0);
    @(posedge clk); #1;                                // t+2
    in_valid = 1'b0;
    chk("ovr_t2_flag", overrun, 1);
    chk("ovr_t2_vld", out_valid, 0);
    @(posedge clk); #1;                                // t+3
    chk("ovr_t3_vld", out_valid, 1);
    chk("ovr_t3_val", int'(out_sample), 111);
    in_sample = 333; in_valid = 1'b1;
    @(posedge clk); #1;                                // t+4
    in_valid = 1'b0;
    chk("ovr_t4_vld", out_valid, 0);
    @(posedge clk); #1;                                // t+5
    chk("ovr_t5_vld", out_valid, 0);
    @(posedge clk); #1;                                // t+6
    chk("ovr_t6_vld", out_valid, 1);
    chk("ovr_t6_val", int'(out_sample), 333);
    chk("ovr_sticky", overrun, 1);
    do_reset();
    chk("ovr_cleared", overrun, 0);

    // Reset landing in MIX abandons the sample; in_valid under reset ignored.
    in_sample = 777; enable = 1'b0; in_valid = 1'b1;   // t
    @(posedge clk); #1;                                // t+1
    in_valid = 1'b0;
    @(posedge clk); #1;                                // t+2 (MIX)
    reset = 1'b1;
    @(posedge clk); #1;                                // t+3
    chk("rstmix_vld", out_valid, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    p = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) p++;
      @(posedge clk); #1;
    end
    chk("rstmix_no_pulse", p, 0);
    chk("rstmix_no_ovr", overrun, 0);
    send(16'sd50, 1'b1, 10'd1, 4'd15, y, lat, pulses);
    chk("rstmix_next_val", int'(y), 50);
    send(16'sd60, 1'b1, 10'd1, 4'd15, y, lat, pulses);
    chk("rstmix_echo_val", int'(y), 106);      // 60 + (15*50)>>>4

    // Fill and wrap: write garbage over the whole ring, reset, then feed a
    // constant; the first 1000 outputs must not see the garbage.
    for (int i = 0; i < DEPTH; i++)
      send(DW'(i * 97 - 30000), 1'b1, 10'd0, 4'd0, y, lat, pulses);
    do_reset();
    for (int n = 1; n <= 1100; n++) begin
      send(16'sd1000, 1'b1, 10'd1000, 4'd15, y, lat, pulses);
      chk($sformatf("fill%0d_value", n), int'(y), (n <= 1000) ? 1000 : 1937);
      chk($sformatf("fill%0d_lat_pulses", n), lat * 10 + pulses, 31);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
